// File: rtl/sample_arbiter.sv
// sample_arbiter: shares one 48-bit sample serializer among four producers
// using round-robin arbitration with optional fixed priority for requester 0.
module sample_arbiter #(
  parameter int NREQ   = 4,
  parameter bit PRIO0  = 1'b1,
  parameter bit TAG_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [48*NREQ-1:0]   req_sample,
  input  logic [NREQ-1:0]      req_rdy,
  output logic [NREQ-1:0]      req_ack,
  input  logic [NREQ-1:0]      enable,
  output logic [47:0]          out_sample,
  output logic                 out_rdy,
  input  logic                 out_ack,
  output logic [1:0]           grant_idx,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} state_t;
  state_t state, state_nx;
  logic [NREQ-1:0] elig;
  logic [1:0] last, win, idx;
  logic [47:0] win_sample, tag_sample;
  assign elig = req_rdy & enable;
  assign win_sample = req_sample[48*win +: 48];
  assign tag_sample = TAG_EN ? {win, win_sample[45:0]} : win_sample;
  assign busy = (state == LOAD) || (state == SEND);
  // scan offsets 4..1 so the lowest offset after last is written last and wins
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) win = idx;
    end
    if (PRIO0 && elig[0]) win = 2'd0;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = |elig ? LOAD : IDLE;
      LOAD: state_nx = SEND;
      SEND: state_nx = out_ack ? ACK : SEND;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_rdy    <= 1'b0;
      req_ack    <= '0;
      out_sample <= '0;
      grant_idx  <= '0;
      last       <= 2'd3;
    end else begin
      req_ack <= '0;
      if (state == IDLE && |elig) begin
        grant_idx  <= win;
        out_sample <= tag_sample;
      end
      if (state == LOAD) out_rdy <= 1'b1;
      if (state == SEND && out_ack) begin
        out_rdy            <= 1'b0;
        req_ack[grant_idx] <= 1'b1;
        last               <= grant_idx;
      end
    end
endmodule

// File: tb/tb_sample_arbiter.sv
// tb_sample_arbiter: table-driven scoreboard bench for two sample_arbiter
// configurations (priority/no-tag and round-robin/tagged).
module tb_sample_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][191:0] rs;
  logic [1:0][3:0]   rr, en_v, ack;
  logic [1:0]        oa, ordy, bsy;
  logic [1:0][47:0]  os;
  logic [1:0][1:0]   gi;
  logic [3:0]  ack_p, ack_r;
  logic [47:0] os_p, os_r;
  logic [1:0]  gi_p, gi_r;
  logic        ordy_p, ordy_r, bsy_p, bsy_r;
  assign ack  = {ack_r, ack_p};
  assign os   = {os_r, os_p};
  assign gi   = {gi_r, gi_p};
  assign ordy = {ordy_r, ordy_p};
  assign bsy  = {bsy_r, bsy_p};

  sample_arbiter #(.PRIO0(1'b1), .TAG_EN(1'b0)) u_prio (
    .clk(clk), .reset(reset), .req_sample(rs[0]), .req_rdy(rr[0]), .req_ack(ack_p),
    .enable(en_v[0]), .out_sample(os_p), .out_rdy(ordy_p), .out_ack(oa[0]),
    .grant_idx(gi_p), .busy(bsy_p));
  sample_arbiter #(.PRIO0(1'b0), .TAG_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .req_sample(rs[1]), .req_rdy(rr[1]), .req_ack(ack_r),
    .enable(en_v[1]), .out_sample(os_r), .out_rdy(ordy_r), .out_ack(oa[1]),
    .grant_idx(gi_r), .busy(bsy_r));

  localparam logic [191:0] SB = {48'hDDDDDDDDDDDD, 48'hCCCCCCCCCCCC, 48'hBBBBBBBBBBBB, 48'hAAAAAAAAAAAA};
  localparam logic [191:0] SP = {48'h333333333333, 48'h222222222222, 48'h111111111111, 48'h0123456789AB};

  typedef struct {
    bit          rst;
    int          d;
    logic [3:0]  rdy;
    logic [3:0]  en;
    logic [191:0] s;
    logic [1:0]  g;
    logic [47:0] o;
    int          dly;
  } vec_t;
  typedef struct {
    logic [1:0]  g;
    logic [47:0] o;
  } exp_t;

  exp_t q[$];
  vec_t tbl[12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rr = '0;
    oa = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_chk(input int d);
    int n;
    exp_t e;
    n = 0;
    while (!ordy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd2);
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty");
      return;
    end
    e = q.pop_front();
    chk("grant_idx", 64'(gi[d]), 64'(e.g));
    chk("out_sample", 64'(os[d]), 64'(e.o));
    chk("busy", 64'(bsy[d]), 64'd1);
  endtask

  task automatic ack_chk(input int d, input logic [1:0] g, input int dly);
    logic [3:0] m;
    m = 4'b0001 << g;
    repeat (dly) @(negedge clk);
    chk("out_rdy_held", 64'(ordy[d]), 64'd1);
    oa[d] = 1'b1;
    @(negedge clk);
    oa[d] = 1'b0;
    chk("req_ack", 64'(ack[d]), 64'(m));
    chk("out_rdy_drop", 64'(ordy[d]), 64'd0);
    @(negedge clk);
    chk("req_ack_clear", 64'(ack[d]), 64'd0);
  endtask

  task automatic xfer(input int d, input logic [3:0] rdy, input logic [3:0] en,
                      input logic [191:0] s, input logic [1:0] g, input logic [47:0] o, input int dly);
    rr[d] = rdy;
    en_v[d] = en;
    rs[d] = s;
    q.push_back('{g, o});
    wait_chk(d);
    ack_chk(d, g, dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 0, 4'b0001, 4'b1111, SP, 2'd0, 48'h0123456789AB, 8};
    tbl[1]  = '{1, 1, 4'b1111, 4'b1111, SB, 2'd0, 48'h2AAAAAAAAAAA, 2};
    tbl[2]  = '{0, 1, 4'b1111, 4'b1111, SB, 2'd1, 48'h7BBBBBBBBBBB, 1};
    tbl[3]  = '{0, 1, 4'b1111, 4'b1111, SB, 2'd2, 48'h8CCCCCCCCCCC, 0};
    tbl[4]  = '{0, 1, 4'b1111, 4'b1111, SB, 2'd3, 48'hDDDDDDDDDDDD, 3};
    tbl[5]  = '{0, 1, 4'b1111, 4'b1111, SB, 2'd0, 48'h2AAAAAAAAAAA, 1};
    tbl[6]  = '{0, 1, 4'b1111, 4'b1111, SB, 2'd1, 48'h7BBBBBBBBBBB, 1};
    tbl[7]  = '{1, 1, 4'b1111, 4'b0101, SB, 2'd0, 48'h2AAAAAAAAAAA, 1};
    tbl[8]  = '{0, 1, 4'b1111, 4'b0101, SB, 2'd2, 48'h8CCCCCCCCCCC, 2};
    tbl[9]  = '{0, 1, 4'b1111, 4'b0101, SB, 2'd0, 48'h2AAAAAAAAAAA, 0};
    tbl[10] = '{0, 1, 4'b1111, 4'b0101, SB, 2'd2, 48'h8CCCCCCCCCCC, 1};
    tbl[11] = '{1, 1, 4'b1000, 4'b1111, {48'h000000000001, 144'h0}, 2'd3, 48'hC00000000001, 0};

    rs = '0;
    rr = '0;
    en_v = '1;
    oa = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_rdy", 64'(ordy[d]), 64'd0);
      chk("rst_req_ack", 64'(ack[d]), 64'd0);
      chk("rst_busy", 64'(bsy[d]), 64'd0);
      chk("rst_out_sample", 64'(os[d]), 64'd0);
      chk("rst_grant_idx", 64'(gi[d]), 64'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      xfer(tbl[i].d, tbl[i].rdy, tbl[i].en, tbl[i].s, tbl[i].g, tbl[i].o, tbl[i].dly);
    end

    // priority: requester 0 arrives while requester 1 is being sent
    do_reset();
    rs[0] = SP;
    en_v[0] = 4'b1111;
    rr[0] = 4'b1110;
    q.push_back('{2'd1, 48'h111111111111});
    wait_chk(0);
    rr[0] = 4'b1111;
    ack_chk(0, 2'd1, 3);
    xfer(0, 4'b1101, 4'b1111, SP, 2'd0, 48'h0123456789AB, 1);
    xfer(0, 4'b1100, 4'b1111, SP, 2'd2, 48'h222222222222, 1);
    rr[0] = 4'b0000;

    // out_ack outside SEND is ignored
    @(negedge clk);
    @(negedge clk);
    oa[0] = 1'b1;
    @(negedge clk);
    oa[0] = 1'b0;
    chk("idle_ack_req_ack", 64'(ack[0]), 64'd0);
    chk("idle_ack_out_rdy", 64'(ordy[0]), 64'd0);
    @(negedge clk);
    chk("idle_ack_busy", 64'(bsy[0]), 64'd0);
    chk("idle_ack_req_ack2", 64'(ack[0]), 64'd0);

    // withdrawn req_rdy during SEND still gets its ack
    do_reset();
    rs[1] = SB;
    en_v[1] = 4'b1111;
    rr[1] = 4'b0100;
    q.push_back('{2'd2, 48'h8CCCCCCCCCCC});
    wait_chk(1);
    rr[1] = 4'b0000;
    ack_chk(1, 2'd2, 2);

    // async reset while in SEND
    do_reset();
    xfer(1, 4'b1111, 4'b1111, SB, 2'd0, 48'h2AAAAAAAAAAA, 1);
    q.push_back('{2'd1, 48'h7BBBBBBBBBBB});
    wait_chk(1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_rdy", 64'(ordy[1]), 64'd0);
    chk("async_req_ack", 64'(ack[1]), 64'd0);
    chk("async_busy", 64'(bsy[1]), 64'd0);
    chk("async_grant_idx", 64'(gi[1]), 64'd0);
    #1 reset = 1'b0;
    q.push_back('{2'd0, 48'h2AAAAAAAAAAA});
    wait_chk(1);
    ack_chk(1, 2'd0, 0);
    rr[1] = 4'b0000;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
